// File: rtl/apb_pkg.sv
// Shared APB widths, slave-select decode field and requester state encoding.
package apb_pkg;
   localparam int APB_AW  = 16;
   localparam int APB_DW  = 16;
   localparam int SEL_MSB = 15;
   localparam int SEL_LSB = 14;
   localparam int SEL_W   = SEL_MSB - SEL_LSB + 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_t;

   function automatic logic [SEL_W-1:0] sel_idx(input logic [SEL_MSB:SEL_LSB] field);
      return field;
   endfunction
endpackage

// File: rtl/apb_if.sv
// APB bus bundle between one requester and its responders; psel is one-hot, one bit per slave.
interface apb_if #(
   parameter int NSLAVES = 4
);
   logic [NSLAVES-1:0]         psel;
   logic                       penable;
   logic                       pwrite;
   logic [apb_pkg::APB_AW-1:0] paddr;
   logic [apb_pkg::APB_DW-1:0] pwdata;
   logic [apb_pkg::APB_DW-1:0] prdata;
   logic                       pready;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready
   );
endinterface

// File: rtl/apb_addr_decode.sv
// Combinational slave decode: upper address bits to a one-hot select, flagging indices with no slave.
module apb_addr_decode
   import apb_pkg::*;
#(
   parameter int NSLAVES = 4
) (
   input  logic [APB_AW-1:0]  addr_i,
   output logic [NSLAVES-1:0] sel_o,
   output logic               miss_o
);
   logic [SEL_W-1:0] idx;
   logic             unused_lo;

   assign idx       = sel_idx(addr_i[SEL_MSB:SEL_LSB]);
   assign unused_lo = ^addr_i[SEL_LSB-1:0];

   always_comb begin
      sel_o  = '0;
      miss_o = 1'b1;
      for (int i = 0; i < NSLAVES; i++) begin
         if (int'(idx) == i) begin
            sel_o[i] = 1'b1;
            miss_o   = 1'b0;
         end
      end
   end
endmodule

// File: rtl/apb_master.sv
// APB requester: one outstanding command turned into a SETUP/ACCESS transfer, with a watchdog.
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETUP  | psel asserted, penable low, exactly one cycle
// ACCESS | psel and penable high, waiting for pready or watchdog expiry
// RESP   | response presented and held until rsp_ready
module apb_master
   import apb_pkg::*;
#(
   parameter int NSLAVES = 4,
   parameter int TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [APB_AW-1:0] cmd_addr_i,
   input  logic [APB_DW-1:0] cmd_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [APB_DW-1:0] rsp_rdata_o,
   output logic              rsp_err_o,
   apb_if.master             bus
);
   localparam int              WD_W    = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE   = IDLE;
   localparam logic [1:0] S_SETUP  = SETUP;
   localparam logic [1:0] S_ACCESS = ACCESS;
   localparam logic [1:0] S_RESP   = RESP;

   logic [1:0]         state_q, state_d;
   logic [NSLAVES-1:0] sel_q, sel_d;
   logic               pwrite_q, pwrite_d;
   logic [APB_AW-1:0]  paddr_q, paddr_d;
   logic [APB_DW-1:0]  pwdata_q, pwdata_d;
   logic [WD_W-1:0]    wdog_q, wdog_d;
   logic [APB_DW-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic               rsp_err_q, rsp_err_d;

   logic [NSLAVES-1:0] dec_sel;
   logic               dec_miss;

   apb_addr_decode #(.NSLAVES(NSLAVES)) u_dec (
      .addr_i (cmd_addr_i),
      .sel_o  (dec_sel),
      .miss_o (dec_miss)
   );

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      wdog_d      = wdog_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i && cmd_ready_o) begin
               pwrite_d = cmd_write_i;
               paddr_d  = cmd_addr_i;
               pwdata_d = cmd_wdata_i;
               sel_d    = dec_sel;
               if (dec_miss) begin
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  state_d     = S_RESP;
               end else begin
                  state_d = S_SETUP;
               end
            end
         end
         S_SETUP: state_d = S_ACCESS;
         S_ACCESS: begin
            // pready is checked first so a completion on the expiry edge still counts as success
            if (bus.pready) begin
               rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
               rsp_err_d   = 1'b0;
               state_d     = S_RESP;
            end else if (wdog_q == WD_LAST) begin
               rsp_rdata_d = '0;
               rsp_err_d   = 1'b1;
               state_d     = S_RESP;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               wdog_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state_q     <= S_IDLE;
         sel_q       <= '0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         wdog_q      <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         wdog_q      <= wdog_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // reset gates ready so nothing is accepted while preset is low
   assign cmd_ready_o = preset && (state_q == S_IDLE);
   assign rsp_valid_o = (state_q == S_RESP);
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

   assign bus.psel    = (state_q == S_SETUP || state_q == S_ACCESS) ? sel_q : '0;
   assign bus.penable = (state_q == S_ACCESS);
   assign bus.pwrite  = pwrite_q;
   assign bus.paddr   = paddr_q;
   assign bus.pwdata  = pwdata_q;
endmodule
